// File: rtl/i2c_pkg.sv
// Shared definitions for the byte-level I2C master: command codes, engine
// states, quarter-phase numbering and open-drain line levels.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_STOP  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WBIT   = 3'd2,
    ST_RBIT   = 3'd3,
    ST_ACK_RX = 3'd4,
    ST_ACK_TX = 3'd5,
    ST_STOP   = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  localparam logic REL = 1'b1;
  localparam logic LOW = 1'b0;

  localparam logic [1:0] PH_Q0 = 2'd0;
  localparam logic [1:0] PH_Q1 = 2'd1;
  localparam logic [1:0] PH_Q2 = 2'd2;
  localparam logic [1:0] PH_Q3 = 2'd3;

  // SCL level inside a data/ack bit frame: high only in the middle two quarters.
  function automatic logic frame_scl(input logic [1:0] ph);
    return ((ph == PH_Q1) || (ph == PH_Q2)) ? REL : LOW;
  endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-bit timebase: counts CLK_DIV cycles per quarter and steps a 2-bit
// phase q0..q3; cleared when a command is accepted.
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       run,
  output logic       tick,
  output logic [1:0] phase,
  output logic       first
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic [1:0]    phase_r;

  assign tick  = run & (cnt_r == CNT_MAX);
  assign phase = phase_r;
  assign first = (cnt_r == {CW{1'b0}});

  // Quarter counter and phase register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r   <= {CW{1'b0}};
      phase_r <= PH_Q0;
    end else if (clear) begin
      cnt_r   <= {CW{1'b0}};
      phase_r <= PH_Q0;
    end else if (run) begin
      if (cnt_r == CNT_MAX) begin
        cnt_r   <= {CW{1'b0}};
        phase_r <= phase_r + 2'd1;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: executes one START / WRITE / READ / STOP command at a
// time and drives SCL/SDA as registered open-drain tristate controls.
module i2c_byte_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] tx_data,
  input  logic       tx_ack,
  output logic [7:0] rx_data,
  output logic       rx_ack,
  output logic       done,
  output logic       busy,
  output logic       scl_t,
  output logic       sda_t,
  input  logic       sda_i
);

  state_e     state_r, state_s;
  logic       accept_s, run_s, tick_s, first_s, frame_end_s, sample_s;
  logic [1:0] phase_s;
  logic [7:0] shift_r;
  logic [2:0] bit_r;
  logic       tx_ack_r, busy_r, done_r;
  logic [7:0] rx_data_r;
  logic       rx_ack_r;
  logic       scl_r, sda_r, scl_s, sda_s;
  logic [1:0] sda_sync_r;

  assign accept_s    = cmd_valid & ~busy_r;
  assign run_s       = (state_r != ST_IDLE) && (state_r != ST_DONE);
  assign frame_end_s = tick_s & (phase_s == PH_Q3);
  assign sample_s    = tick_s & (phase_s == PH_Q2);

  assign cmd_ready = ~busy_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign rx_data   = rx_data_r;
  assign rx_ack    = rx_ack_r;
  assign scl_t     = scl_r;
  assign sda_t     = sda_r;

  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clock (clock),
    .reset (reset),
    .clear (accept_s),
    .run   (run_s),
    .tick  (tick_s),
    .phase (phase_s),
    .first (first_s)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: each state lasts whole 4-quarter frames.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmd)
            CMD_START: state_s = ST_START;
            CMD_WRITE: state_s = ST_WBIT;
            CMD_READ:  state_s = ST_RBIT;
            CMD_STOP:  state_s = ST_STOP;
            default:   state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START, ST_STOP, ST_ACK_RX, ST_ACK_TX: begin
        if (frame_end_s) state_s = ST_DONE;
        else             state_s = state_r;
      end
      ST_WBIT: begin
        if (frame_end_s && (bit_r == 3'd7)) state_s = ST_ACK_RX;
        else                                 state_s = ST_WBIT;
      end
      ST_RBIT: begin
        if (frame_end_s && (bit_r == 3'd7)) state_s = ST_ACK_TX;
        else                                 state_s = ST_RBIT;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Line levels per state/phase; idle and done hold the previous levels.
  always_comb begin
    scl_s = scl_r;
    sda_s = sda_r;
    case (state_r)
      ST_START: begin
        case (phase_s)
          // Repeated START: release SDA one cycle before SCL.
          PH_Q0: begin
            sda_s = REL;
            scl_s = first_s ? scl_r : REL;
          end
          PH_Q1: begin
            scl_s = REL;
            sda_s = LOW;
          end
          default: begin
            scl_s = LOW;
            sda_s = LOW;
          end
        endcase
      end
      ST_WBIT: begin
        scl_s = frame_scl(phase_s);
        sda_s = shift_r[7];
      end
      ST_RBIT, ST_ACK_RX: begin
        scl_s = frame_scl(phase_s);
        sda_s = REL;
      end
      ST_ACK_TX: begin
        scl_s = frame_scl(phase_s);
        sda_s = tx_ack_r;
      end
      ST_STOP: begin
        case (phase_s)
          // Pull SCL low before SDA so a released bus never sees a false START.
          PH_Q0: begin
            scl_s = LOW;
            sda_s = first_s ? sda_r : LOW;
          end
          PH_Q3: begin
            scl_s = REL;
            sda_s = REL;
          end
          default: begin
            scl_s = REL;
            sda_s = LOW;
          end
        endcase
      end
      default: begin
        scl_s = scl_r;
        sda_s = sda_r;
      end
    endcase
  end

  // Registered open-drain controls and the SDA readback synchroniser.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_r      <= REL;
      sda_r      <= REL;
      sda_sync_r <= 2'b11;
    end else begin
      scl_r      <= scl_s;
      sda_r      <= sda_s;
      sda_sync_r <= {sda_sync_r[0], sda_i};
    end
  end

  // Handshake, shift register, bit counter and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      shift_r   <= 8'h00;
      bit_r     <= 3'd0;
      tx_ack_r  <= 1'b1;
      rx_data_r <= 8'h00;
      rx_ack_r  <= 1'b1;
    end else begin
      done_r <= (state_r == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            busy_r   <= 1'b1;
            shift_r  <= tx_data;
            tx_ack_r <= tx_ack;
            bit_r    <= 3'd0;
          end
        end
        ST_WBIT: begin
          if (frame_end_s) begin
            shift_r <= {shift_r[6:0], 1'b0};
            bit_r   <= bit_r + 3'd1;
          end
        end
        ST_RBIT: begin
          if (sample_s)    shift_r <= {shift_r[6:0], sda_sync_r[1]};
          if (frame_end_s) bit_r   <= bit_r + 3'd1;
        end
        ST_ACK_RX: begin
          if (sample_s) rx_ack_r <= sda_sync_r[1];
        end
        ST_ACK_TX: begin
          if (frame_end_s) rx_data_r <= shift_r;
        end
        ST_DONE: busy_r <= 1'b0;
        default: busy_r <= busy_r;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Self-checking bench for i2c_byte_master: command table with a scoreboard
// queue, a wired-AND slave model, plus held-command and mid-WRITE reset cases.
module tb_i2c_byte_master;
  import i2c_pkg::*;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic [7:0] rx_data;
  logic       rx_ack;
  logic       done;
  logic       busy;
  logic       scl_t;
  logic       sda_t;
  logic       sda_i;
  logic       slave_sda;

  assign sda_i = sda_t & slave_sda;

  always #5 clock = ~clock;

  i2c_byte_master #(.CLK_DIV(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .tx_data   (tx_data),
    .tx_ack    (tx_ack),
    .rx_data   (rx_data),
    .rx_ack    (rx_ack),
    .done      (done),
    .busy      (busy),
    .scl_t     (scl_t),
    .sda_t     (sda_t),
    .sda_i     (sda_i)
  );

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic [7:0] slave_byte;
    logic       slave_ack;
    int         lat;
    int         rises;
    logic [8:0] pattern;
    int         hi_fall;
    int         hi_rise;
    logic       fin_scl;
    logic       fin_sda;
    logic [7:0] rxd;
    logic       rxa;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[8];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] c, input logic [7:0] txd, input logic txa,
                              input logic [7:0] sb, input logic sa, input int rises,
                              input int hf, input int hr, input logic fs, input logic fd,
                              input logic [7:0] rxd, input logic rxa);
    vec_t v;
    v.cmd        = c;
    v.tx_data    = txd;
    v.tx_ack     = txa;
    v.slave_byte = sb;
    v.slave_ack  = sa;
    v.rises      = rises;
    v.hi_fall    = hf;
    v.hi_rise    = hr;
    v.fin_scl    = fs;
    v.fin_sda    = fd;
    v.rxd        = rxd;
    v.rxa        = rxa;
    v.lat        = ((c == CMD_WRITE) || (c == CMD_READ)) ? 36 * D + 1 : 4 * D + 1;
    if (c == CMD_WRITE)     v.pattern = {txd, 1'b1};
    else if (c == CMD_READ) v.pattern = {8'hFF, txa};
    else                    v.pattern = 9'h000;
    return v;
  endfunction

  task automatic issue(input vec_t v, input bit push);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd       = v.cmd;
    tx_data   = v.tx_data;
    tx_ack    = v.tx_ack;
    if (v.cmd == CMD_READ) slave_sda = v.slave_byte[7];
    if (push) exp_q.push_back(v);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Follows one command to its done pulse, acting as the slave on SDA.
  task automatic track(input vec_t v);
    int         n = 0;
    int         rises = 0;
    int         fc = 0;
    int         hf = 0;
    int         hr = 0;
    int         gap = 0;
    bit         seen = 1'b0;
    logic [8:0] pat = 9'h000;
    logic       ps = scl_t;
    logic       pd = sda_t;
    vec_t       e;
    while (!seen && n < 40 * D + 20) begin
      @(posedge clock);
      #1;
      n++;
      if (!ps && scl_t) begin
        rises++;
        pat = {pat[7:0], sda_t};
      end
      if (ps && !scl_t) begin
        fc++;
        if (v.cmd == CMD_WRITE) begin
          if (fc == 8)      slave_sda = v.slave_ack;
          else if (fc == 9) slave_sda = 1'b1;
        end else if (v.cmd == CMD_READ) begin
          if (fc < 8) slave_sda = v.slave_byte[7 - fc];
          else        slave_sda = 1'b1;
        end
      end
      if (ps && scl_t && pd && !sda_t) hf++;
      if (ps && scl_t && !pd && sda_t) hr++;
      if (done) seen = 1'b1;
      else if (!busy) gap++;
      ps = scl_t;
      pd = sda_t;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("latency", n, e.lat);
      chk("scl_rises", rises, e.rises);
      if (e.rises == 9) chk("sda_pattern", {23'd0, pat}, {23'd0, e.pattern});
      chk("start_cond", hf, e.hi_fall);
      chk("stop_cond", hr, e.hi_rise);
      chk("busy_gap", gap, 32'd0);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      chk("ready_at_done", {31'd0, cmd_ready}, 32'd1);
      chk("rx_ack", {31'd0, rx_ack}, {31'd0, e.rxa});
      chk("rx_data", {24'd0, rx_data}, {24'd0, e.rxd});
      chk("final_scl", {31'd0, scl_t}, {31'd0, e.fin_scl});
      chk("final_sda", {31'd0, sda_t}, {31'd0, e.fin_sda});
    end
  endtask

  task automatic done_tail();
    @(posedge clock);
    #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
  endtask

  task automatic check_reset_state();
    chk("rst_scl", {31'd0, scl_t}, 32'd1);
    chk("rst_sda", {31'd0, sda_t}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_rx_ack", {31'd0, rx_ack}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t st, wr, rd, sp, st2, wr2, st3;
    int   f;
    int   k;
    logic ps;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    tx_data   = 8'h00;
    tx_ack    = 1'b0;
    slave_sda = 1'b1;

    //          cmd        txd    txa   slave  sack  rise hf hr fscl  fsda  rxd    rxa
    tbl[0] = mk(CMD_START, 8'h00, 1'b0, 8'h00, 1'b1, 0,   1, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    tbl[1] = mk(CMD_WRITE, 8'hA5, 1'b0, 8'h00, 1'b0, 9,   0, 0, 1'b0, 1'b1, 8'h00, 1'b0);
    tbl[2] = mk(CMD_READ,  8'h00, 1'b1, 8'h3C, 1'b1, 9,   0, 0, 1'b0, 1'b1, 8'h3C, 1'b0);
    tbl[3] = mk(CMD_WRITE, 8'h5A, 1'b0, 8'h00, 1'b1, 9,   0, 0, 1'b0, 1'b1, 8'h3C, 1'b1);
    tbl[4] = mk(CMD_START, 8'h00, 1'b0, 8'h00, 1'b1, 1,   1, 0, 1'b0, 1'b0, 8'h3C, 1'b1);
    tbl[5] = mk(CMD_READ,  8'h00, 1'b0, 8'hC3, 1'b1, 9,   0, 0, 1'b0, 1'b0, 8'hC3, 1'b1);
    tbl[6] = mk(CMD_STOP,  8'h00, 1'b0, 8'h00, 1'b1, 1,   0, 1, 1'b1, 1'b1, 8'hC3, 1'b1);
    tbl[7] = mk(CMD_STOP,  8'h00, 1'b0, 8'h00, 1'b1, 1,   0, 1, 1'b1, 1'b1, 8'hC3, 1'b1);
    st  = mk(CMD_START, 8'h00, 1'b0, 8'h00, 1'b1, 0, 1, 0, 1'b0, 1'b0, 8'hC3, 1'b1);
    wr  = mk(CMD_WRITE, 8'h96, 1'b0, 8'h00, 1'b0, 9, 0, 0, 1'b0, 1'b1, 8'hC3, 1'b0);
    rd  = mk(CMD_READ,  8'h00, 1'b1, 8'h69, 1'b1, 9, 0, 0, 1'b0, 1'b1, 8'h69, 1'b0);
    sp  = mk(CMD_STOP,  8'h00, 1'b0, 8'h00, 1'b1, 1, 0, 1, 1'b1, 1'b1, 8'h69, 1'b0);
    st2 = mk(CMD_START, 8'h00, 1'b0, 8'h00, 1'b1, 0, 1, 0, 1'b0, 1'b0, 8'h69, 1'b0);
    wr2 = mk(CMD_WRITE, 8'hA5, 1'b0, 8'h00, 1'b0, 9, 0, 0, 1'b0, 1'b1, 8'h69, 1'b0);
    st3 = mk(CMD_START, 8'h00, 1'b0, 8'h00, 1'b1, 0, 1, 0, 1'b0, 1'b0, 8'h00, 1'b1);

    repeat (3) @(posedge clock);
    #1;
    check_reset_state();
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      issue(tbl[i], 1'b1);
      track(tbl[i]);
      done_tail();
    end

    // READ held on cmd_valid throughout a WRITE: taken only after done.
    issue(st, 1'b1);
    track(st);
    done_tail();
    issue(wr, 1'b1);
    cmd_valid = 1'b1;
    cmd       = CMD_READ;
    tx_ack    = rd.tx_ack;
    track(wr);
    slave_sda = rd.slave_byte[7];
    exp_q.push_back(rd);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    chk("held_accept_busy", {31'd0, busy}, 32'd1);
    chk("held_accept_done", {31'd0, done}, 32'd0);
    track(rd);
    done_tail();
    issue(sp, 1'b1);
    track(sp);
    done_tail();
    issue(st2, 1'b1);
    track(st2);
    done_tail();

    // Reset asserted while bit 4 of a WRITE is on the bus.
    issue(wr2, 1'b0);
    f  = 0;
    k  = 0;
    ps = scl_t;
    while (f < 4 && k < 40 * D) begin
      @(posedge clock);
      #1;
      k++;
      if (ps && !scl_t) f++;
      ps = scl_t;
    end
    chk("reach_bit4", f, 32'd4);
    repeat (D) @(posedge clock);
    #1;
    chk("pre_reset_scl", {31'd0, scl_t}, 32'd0);
    chk("pre_reset_sda", {31'd0, sda_t}, 32'd0);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_reset_state();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    issue(st3, 1'b1);
    track(st3);
    done_tail();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
